chess_layout_matrix: RTL and testbench

// - Holds the 8x8 chessboard piece layout as a flat 256-bit vector for the LCD renderer in ChessEngine.
// - Four pushbuttons move a board cursor; a Left+Right chord picks up a piece, and a second chord drops it.
// - No move-legality checks: any piece may move to any square, and the target contents are overwritten (capture).

---
 rtl/chess_layout_matrix.sv | 158 +++++++++++++++
 tb/tb_chess_layout_matrix.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/chess_layout_matrix.sv
// Chessboard layout register for the LCD renderer: four debounced keys move a cursor,
// a Left+Right chord picks a piece up and a second chord drops it (no legality checks).
module chess_layout_matrix #(
    parameter int unsigned CHESS_SQUARES   = 64,
    parameter int unsigned SQUARE_WIDTH    = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                                  clock,
    input  logic                                  resetApp,
    input  logic                                  KeyLeft,
    input  logic                                  KeyUp,
    input  logic                                  KeyDown,
    input  logic                                  KeyRight,
    output logic [CHESS_SQUARES*SQUARE_WIDTH-1:0] Matrix,
    output logic [5:0]                            CursorIdx,
    output logic                                  SelectActive,
    output logic [5:0]                            SelectIdx
);

    localparam int unsigned KEYS     = 4;
    localparam int unsigned KEY_L    = 0;
    localparam int unsigned KEY_U    = 1;
    localparam int unsigned KEY_D    = 2;
    localparam int unsigned KEY_R    = 3;
    localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned MATRIX_W = CHESS_SQUARES * SQUARE_WIDTH;
    localparam int unsigned BASE_W   = $clog2(MATRIX_W);

    localparam logic [5:0] START_CURSOR = 6'd52;

    // Square 63 at the MSB end: row7, row6, four empty rows, row1, row0 (each col7..col0).
    localparam logic [MATRIX_W-1:0] START_BOARD = {
        32'h4236_5324,
        32'h1111_1111,
        128'h0,
        32'h9999_9999,
        32'hCABE_DBAC
    };

    logic [KEYS-1:0]  keyRaw;
    logic [KEYS-1:0]  syncA;
    logic [KEYS-1:0]  syncB;
    logic [KEYS-1:0]  accepted;
    logic [KEYS-1:0]  acceptedPrev;
    logic [CNT_W-1:0] debCnt [KEYS];

    logic [KEYS-1:0]  pressEv;
    logic             bothDown;
    logic             chordHeld;
    logic             chordEv;
    logic             moveLeft;
    logic             moveRight;

    logic [2:0]              rowNext;
    logic [2:0]              colNext;
    logic [5:0]              cursorNext;
    logic                    selActNext;
    logic [5:0]              selIdxNext;
    logic [MATRIX_W-1:0]     boardNext;
    logic [BASE_W-1:0]       curBase;
    logic [BASE_W-1:0]       selBase;
    logic [SQUARE_WIDTH-1:0] cursorSquare;
    logic [SQUARE_WIDTH-1:0] selSquare;

    assign keyRaw = {KeyRight, KeyDown, KeyUp, KeyLeft};

    // Two-flop synchronizer plus per-key debounce; keys idle high (released).
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            syncA        <= '1;
            syncB        <= '1;
            accepted     <= '1;
            acceptedPrev <= '1;
            for (int k = 0; k < KEYS; k++) begin
                debCnt[k] <= '0;
            end
        end else begin
            syncA        <= keyRaw;
            syncB        <= syncA;
            acceptedPrev <= accepted;
            for (int k = 0; k < KEYS; k++) begin
                if (syncB[k] == accepted[k]) begin
                    debCnt[k] <= '0;
                end else if (debCnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    accepted[k] <= syncB[k];
                    debCnt[k]   <= '0;
                end else begin
                    debCnt[k] <= debCnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Press = accepted 1->0; the chord swallows Left/Right presses in its own cycle.
    assign pressEv   = acceptedPrev & ~accepted;
    assign bothDown  = ~accepted[KEY_L] & ~accepted[KEY_R];
    assign chordEv   = bothDown & ~chordHeld;
    assign moveLeft  = pressEv[KEY_L] & ~chordEv;
    assign moveRight = pressEv[KEY_R] & ~chordEv;

    assign curBase      = BASE_W'(CursorIdx * SQUARE_WIDTH);
    assign selBase      = BASE_W'(SelectIdx * SQUARE_WIDTH);
    assign cursorSquare = Matrix[curBase +: SQUARE_WIDTH];
    assign selSquare    = Matrix[selBase +: SQUARE_WIDTH];

    always_comb begin
        rowNext    = CursorIdx[5:3];
        colNext    = CursorIdx[2:0];
        selActNext = SelectActive;
        selIdxNext = SelectIdx;
        boardNext  = Matrix;

        if (pressEv[KEY_U] && !pressEv[KEY_D] && rowNext != 3'd0) begin
            rowNext = rowNext - 3'd1;
        end else if (pressEv[KEY_D] && !pressEv[KEY_U] && rowNext != 3'd7) begin
            rowNext = rowNext + 3'd1;
        end
        if (moveLeft && !moveRight && colNext != 3'd0) begin
            colNext = colNext - 3'd1;
        end else if (moveRight && !moveLeft && colNext != 3'd7) begin
            colNext = colNext + 3'd1;
        end
        cursorNext = {rowNext, colNext};

        // Pick up a non-empty square, or drop/cancel a held piece.
        if (chordEv) begin
            if (!SelectActive) begin
                if (cursorSquare != '0) begin
                    selActNext = 1'b1;
                    selIdxNext = CursorIdx;
                end
            end else begin
                selActNext = 1'b0;
                if (CursorIdx != SelectIdx) begin
                    boardNext[curBase +: SQUARE_WIDTH] = selSquare;
                    boardNext[selBase +: SQUARE_WIDTH] = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            chordHeld    <= 1'b0;
            Matrix       <= START_BOARD;
            CursorIdx    <= START_CURSOR;
            SelectActive <= 1'b0;
            SelectIdx    <= '0;
        end else begin
            chordHeld    <= bothDown;
            Matrix       <= boardNext;
            CursorIdx    <= cursorNext;
            SelectActive <= selActNext;
            SelectIdx    <= selIdxNext;
        end
    end

endmodule

// File: tb/tb_chess_layout_matrix.sv
// Directed bench for chess_layout_matrix with a short debounce window.
module tb_chess_layout_matrix;

    localparam logic [3:0] K_L     = 4'b0001;
    localparam logic [3:0] K_U     = 4'b0010;
    localparam logic [3:0] K_D     = 4'b0100;
    localparam logic [3:0] K_R     = 4'b1000;
    localparam logic [3:0] K_CHORD = 4'b1001;

    logic         clock = 1'b0;
    logic         resetApp = 1'b1;
    logic [3:0]   keysN = 4'hF;
    logic [255:0] Matrix;
    logic [5:0]   CursorIdx;
    logic         SelectActive;
    logic [5:0]   SelectIdx;

    logic [255:0] startBoard;
    logic [255:0] expBoard;
    int           checks = 0;
    int           errors = 0;

    always #5 clock = ~clock;

    chess_layout_matrix #(
        .CHESS_SQUARES  (64),
        .SQUARE_WIDTH   (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock       (clock),
        .resetApp    (resetApp),
        .KeyLeft     (keysN[0]),
        .KeyUp       (keysN[1]),
        .KeyDown     (keysN[2]),
        .KeyRight    (keysN[3]),
        .Matrix      (Matrix),
        .CursorIdx   (CursorIdx),
        .SelectActive(SelectActive),
        .SelectIdx   (SelectIdx)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clock);
        keysN = ~mask;
        repeat (hold) @(negedge clock);
        keysN = 4'hF;
        repeat (12) @(negedge clock);
    endtask

    task automatic pressN(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) press(mask, 10);
    endtask

    function automatic logic [3:0] sq(input int idx);
        return Matrix[idx*4 +: 4];
    endfunction

    initial begin
        logic [3:0] back0 [8];
        logic [3:0] back7 [8];
        back0 = '{4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC};
        back7 = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
        startBoard = '0;
        for (int c = 0; c < 8; c++) begin
            startBoard[c*4 +: 4]        = back0[c];
            startBoard[(8 + c)*4 +: 4]  = 4'h9;
            startBoard[(48 + c)*4 +: 4] = 4'h1;
            startBoard[(56 + c)*4 +: 4] = back7[c];
        end
        expBoard = startBoard;

        repeat (3) @(negedge clock);
        resetApp = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_sq0", 256'(sq(0)), 256'(4'hC));
        chk("rst_sq4", 256'(sq(4)), 256'(4'hE));
        chk("rst_sq52", 256'(sq(52)), 256'(4'h1));
        chk("rst_sq20", 256'(sq(20)), 256'(4'h0));
        chk("rst_board", Matrix, startBoard);
        chk("rst_cursor", 256'(CursorIdx), 256'(52));
        chk("rst_selact", 256'(SelectActive), 256'(0));
        chk("rst_selidx", 256'(SelectIdx), 256'(0));

        // Short glitch must be filtered, long hold moves exactly once.
        @(negedge clock);
        keysN = ~K_U;
        repeat (2) @(negedge clock);
        keysN = 4'hF;
        repeat (12) @(negedge clock);
        chk("glitch_reject", 256'(CursorIdx), 256'(52));
        press(K_U, 10);
        chk("up_once", 256'(CursorIdx), 256'(44));
        repeat (20) @(negedge clock);
        chk("up_stable", 256'(CursorIdx), 256'(44));
        press(K_D, 10);
        chk("down_back", 256'(CursorIdx), 256'(52));

        // Pick up pawn on 52, move two rows up, drop on 36.
        press(K_CHORD, 10);
        chk("pick_act", 256'(SelectActive), 256'(1));
        chk("pick_idx", 256'(SelectIdx), 256'(52));
        chk("pick_cursor", 256'(CursorIdx), 256'(52));
        pressN(K_U, 2);
        chk("carry_cursor", 256'(CursorIdx), 256'(36));
        chk("carry_board", Matrix, expBoard);
        press(K_CHORD, 10);
        expBoard[36*4 +: 4] = 4'h1;
        expBoard[52*4 +: 4] = 4'h0;
        chk("drop_sq36", 256'(sq(36)), 256'(4'h1));
        chk("drop_sq52", 256'(sq(52)), 256'(4'h0));
        chk("drop_board", Matrix, expBoard);
        chk("drop_selact", 256'(SelectActive), 256'(0));

        // Edge clamps.
        pressN(K_L, 6);
        chk("clamp_left", 256'(CursorIdx), 256'(32));
        pressN(K_U, 10);
        chk("clamp_top", 256'(CursorIdx), 256'(0));
        pressN(K_D, 3);
        chk("move_down3", 256'(CursorIdx), 256'(24));
        press(K_CHORD, 10);
        chk("empty_chord", 256'(SelectActive), 256'(0));
        pressN(K_R, 9);
        chk("clamp_right", 256'(CursorIdx), 256'(31));
        pressN(K_D, 10);
        chk("clamp_bottom", 256'(CursorIdx), 256'(63));
        pressN(K_L, 3);
        chk("at_king", 256'(CursorIdx), 256'(60));

        // Long-held chord fires once; second chord on same square cancels.
        press(K_CHORD, 40);
        chk("hold_chord_act", 256'(SelectActive), 256'(1));
        chk("hold_chord_idx", 256'(SelectIdx), 256'(60));
        press(K_CHORD, 10);
        chk("cancel_act", 256'(SelectActive), 256'(0));
        chk("cancel_board", Matrix, expBoard);

        // Combined key presses.
        press(K_U | K_D, 10);
        chk("updown_none", 256'(CursorIdx), 256'(60));
        press(K_U | K_L, 10);
        chk("diag_upleft", 256'(CursorIdx), 256'(51));
        press(K_D | K_R, 10);
        chk("diag_downright", 256'(CursorIdx), 256'(60));

        // Reset in the middle of a selection.
        press(K_CHORD, 10);
        chk("sel_king", 256'(SelectActive), 256'(1));
        @(negedge clock);
        resetApp = 1'b1;
        #1;
        chk("midrst_board", Matrix, startBoard);
        chk("midrst_cursor", 256'(CursorIdx), 256'(52));
        chk("midrst_selact", 256'(SelectActive), 256'(0));
        repeat (2) @(negedge clock);
        resetApp = 1'b0;
        repeat (3) @(negedge clock);
        chk("postrst_board", Matrix, startBoard);
        chk("postrst_selidx", 256'(SelectIdx), 256'(0));
        press(K_U, 10);
        chk("postrst_up", 256'(CursorIdx), 256'(44));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
